// File: rtl/rdcla_pkg.sv
// Shared definitions for the recursive-doubling add/sub family: KPG carry
// encoding, default width and the per-bit KPG seed function.
package rdcla_pkg;

    localparam int DEFAULT_WIDTH = 32;

    // {c1,c0}: c1 is the resolved carry once a group is no longer propagate
    typedef logic [1:0] kpg_t;

    localparam kpg_t KPG_KILL = 2'b00;
    localparam kpg_t KPG_PROP = 2'b10;
    localparam kpg_t KPG_GEN  = 2'b11;

    // Seed one bit position from the two addend bits (x = a[i], y = ~b[i])
    function automatic kpg_t kpg_init(input logic x, input logic y);
        kpg_t r;
        if (x & y)
            r = KPG_GEN;
        else if (x ^ y)
            r = KPG_PROP;
        else
            r = KPG_KILL;
        return r;
    endfunction

endpackage

// File: rtl/kpg_merge_cell.sv
// Combinational prefix cell: combines the current group with the group
// immediately below it.
module kpg_merge_cell
    import rdcla_pkg::*;
(
    input  kpg_t cur,
    input  kpg_t prev,
    output kpg_t res
);

    // Kill/generate dominate; propagate passes the lower group through.
    // The unused 01 code resolves to kill so the cell stays fully decoded.
    always_comb begin
        res = KPG_KILL;
        case (cur)
            KPG_KILL: res = KPG_KILL;
            KPG_GEN:  res = KPG_GEN;
            KPG_PROP: res = prev;
            default:  res = KPG_KILL;
        endcase
    end

endmodule

// File: rtl/rdcla_sub_pipe.sv
// Three-stage pipelined Kogge-Stone subtractor: diff = a - b - bin.
// Computed as a + ~b + ~bin. The carry prefix tree is split across S2 and S3,
// and the whole pipeline stalls globally on back-pressure.
module rdcla_sub_pipe
    import rdcla_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int LEVELS = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int STAGES    = 3;
    // Prefix levels evaluated ahead of the S2 register; the rest go before S3
    localparam int S2_LEVELS = (LEVELS + 1) / 2;

    logic              advance;
    logic [STAGES:1]   vld_pipe;

    // Position 0 carries cin; position i+1 is operand bit i
    logic [WIDTH-1:0]  b_inv;
    kpg_t [WIDTH:0]    init_kpg;

    logic              s1_a_msb, s1_b_msb;
    logic [WIDTH-1:0]  s1_hs;
    kpg_t [WIDTH:0]    s1_kpg;

    logic              s2_a_msb, s2_b_msb;
    logic [WIDTH-1:0]  s2_hs;
    kpg_t [WIDTH:0]    s2_kpg;

    kpg_t [WIDTH:0]    lvl [LEVELS+1];
    kpg_t              cout_kpg;
    logic [WIDTH-1:0]  carry;
    logic [WIDTH-1:0]  diff_nxt;
    logic              bout_nxt, ovf_nxt, zero_nxt;

    assign advance   = !vld_pipe[STAGES] || out_ready;
    assign in_ready  = advance;
    assign out_valid = vld_pipe[STAGES];
    assign b_inv     = ~b;

    // Seed the KPG vector; cin = ~bin forces position 0 to generate or kill
    always_comb begin
        init_kpg    = '0;
        init_kpg[0] = bin ? KPG_KILL : KPG_GEN;
        for (int i = 0; i < WIDTH; i++)
            init_kpg[i+1] = kpg_init(a[i], b_inv[i]);
    end

    // Valid shift register; bubbles move with the data on every advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            vld_pipe <= '0;
        else if (advance)
            vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
    end

    // S1: operand MSBs, seed KPG vector and half-sum
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_a_msb <= 1'b0;
            s1_b_msb <= 1'b0;
            s1_hs    <= '0;
            s1_kpg   <= '0;
        end else if (advance) begin
            s1_a_msb <= a[WIDTH-1];
            s1_b_msb <= b[WIDTH-1];
            s1_hs    <= a ^ b_inv;
            s1_kpg   <= init_kpg;
        end
    end

    assign lvl[0] = s1_kpg;

    // Prefix levels: level l merges each position with the one 2^l below.
    // The level right after the S2 cut takes its input from the S2 register.
    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int SPAN = 1 << l;
        kpg_t [WIDTH:0] src;
        if (l == S2_LEVELS) begin : g_from_reg
            assign src = s2_kpg;
        end else begin : g_from_lvl
            assign src = lvl[l];
        end
        for (genvar j = 0; j <= WIDTH; j++) begin : g_bit
            if (j >= SPAN) begin : g_merge
                kpg_merge_cell u_cell (
                    .cur  (src[j]),
                    .prev (src[j-SPAN]),
                    .res  (lvl[l+1][j])
                );
            end else begin : g_pass
                assign lvl[l+1][j] = src[j];
            end
        end
    end

    // S2: partially resolved KPG vector plus carried-along operand info
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_a_msb <= 1'b0;
            s2_b_msb <= 1'b0;
            s2_hs    <= '0;
            s2_kpg   <= '0;
        end else if (advance) begin
            s2_a_msb <= s1_a_msb;
            s2_b_msb <= s1_b_msb;
            s2_hs    <= s1_hs;
            s2_kpg   <= lvl[S2_LEVELS];
        end
    end

    // The top position only reaches back to position 1 after LEVELS levels,
    // so one extra merge against cin resolves the carry out.
    kpg_merge_cell u_cout (
        .cur  (lvl[LEVELS][WIDTH]),
        .prev (lvl[LEVELS][0]),
        .res  (cout_kpg)
    );

    // Resolved carries into each bit, then sum and flags
    always_comb begin
        carry = '0;
        for (int i = 0; i < WIDTH; i++)
            carry[i] = (lvl[LEVELS][i] == KPG_GEN);
        diff_nxt = s2_hs ^ carry;
        bout_nxt = (cout_kpg != KPG_GEN);
        ovf_nxt  = (s2_a_msb != s2_b_msb) && (diff_nxt[WIDTH-1] != s2_a_msb);
        zero_nxt = (diff_nxt == '0);
    end

    // S3: result registers, held while the consumer stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            diff <= '0;
            bout <= 1'b0;
            ovf  <= 1'b0;
            zero <= 1'b0;
        end else if (advance) begin
            diff <= diff_nxt;
            bout <= bout_nxt;
            ovf  <= ovf_nxt;
            zero <= zero_nxt;
        end
    end

endmodule
